// File: rtl/fpdiv_pkg.sv
// Shared defaults and FSM state type for the significand divider.
// Optional early termination is enabled with FPDIV_MANT_EARLY_TERM_EN.
package fpdiv_pkg;

  localparam int SIG_W_DEF = 24;
  localparam int QBITS_DEF = 26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } fpdiv_state_e;

endpackage

// File: rtl/fpdiv_mant_step.sv
// One restoring-division step: compare, conditionally subtract,
// then shift the partial remainder left by one.
module fpdiv_mant_step
  import fpdiv_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic [SIG_W:0]   rem_i,
  input  logic [SIG_W-1:0] d_i,
  output logic             q_bit_o,
  output logic [SIG_W:0]   rem_o
);

  logic [SIG_W:0] d_ext;
  logic [SIG_W:0] diff;

  assign d_ext = {1'b0, d_i};

  always_comb begin
    q_bit_o = (rem_i >= d_ext);
    diff    = q_bit_o ? (rem_i - d_ext) : rem_i;
    rem_o   = {diff[SIG_W-1:0], 1'b0};
  end

endmodule

// File: rtl/fpdiv_mant_iter.sv
// Bit-serial significand divider, one quotient bit per clock.
// Define FPDIV_MANT_EARLY_TERM_EN to finish as soon as the remainder is zero.
module fpdiv_mant_iter
  import fpdiv_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int QBITS = QBITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] m_n,
  input  logic [SIG_W-1:0] m_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QBITS-1:0] q,
  output logic             sticky
);

  localparam int CNT_W = $clog2(QBITS);

  fpdiv_state_e     state_q, state_d;
  logic [SIG_W:0]   rem_q, rem_d;
  logic [SIG_W-1:0] d_q, d_d;
  logic [QBITS-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             step_bit;
  logic [SIG_W:0]   step_rem;
  logic [QBITS-1:0] q_shift;

  fpdiv_mant_step #(
    .SIG_W(SIG_W)
  ) u_step (
    .rem_i  (rem_q),
    .d_i    (d_q),
    .q_bit_o(step_bit),
    .rem_o  (step_rem)
  );

  assign q_shift = {q_q[QBITS-2:0], step_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      d_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      d_q     <= d_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    d_d     = d_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rem_d   = {1'b0, m_n};
          d_d     = m_d;
          q_d     = '0;
          cnt_d   = CNT_W'(QBITS - 1);
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        q_d   = q_shift;
        rem_d = step_rem;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`ifdef FPDIV_MANT_EARLY_TERM_EN
        // Exact quotient: remaining bits are all zero.
        if (step_rem == '0) begin
          q_d     = q_shift << cnt_q;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign q         = q_q;
  assign sticky    = out_valid && (rem_q != '0);

endmodule

// File: tb/tb_fpdiv_mant_iter.sv
// Self-checking bench for fpdiv_mant_iter against a plain-arithmetic
// quotient/remainder model; follows FPDIV_MANT_EARLY_TERM_EN if defined.
module tb_fpdiv_mant_iter;

  localparam int SIG_W = 24;
  localparam int QBITS = 26;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [SIG_W-1:0] m_n;
  logic [SIG_W-1:0] m_d;
  logic             out_valid;
  logic             out_ready;
  logic [QBITS-1:0] q;
  logic             sticky;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  fpdiv_mant_iter #(
    .SIG_W(SIG_W),
    .QBITS(QBITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .m_n      (m_n),
    .m_d      (m_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .sticky   (sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // q = floor(n * 2^(QBITS-1) / d), sticky = remainder nonzero.
  task automatic model(input logic [SIG_W-1:0] mn,
                       input logic [SIG_W-1:0] md,
                       output logic [QBITS-1:0] eq,
                       output logic es, output int el);
    longint num;
    int tz;
    num = longint'(mn) << (QBITS - 1);
    eq  = QBITS'(num / longint'(md));
    es  = (num % longint'(md)) != 0;
    el  = QBITS;
`ifdef FPDIV_MANT_EARLY_TERM_EN
    if (!es && eq != '0) begin
      tz = 0;
      while (tz < QBITS && eq[tz] == 1'b0) tz++;
      el = QBITS - tz;
    end
`else
    tz = 0;
`endif
  endtask

  task automatic do_op(input string tag,
                       input logic [SIG_W-1:0] mn,
                       input logic [SIG_W-1:0] md,
                       input logic [QBITS-1:0] eq,
                       input logic es, input int el,
                       input bit chk_q, input int hold,
                       input bit keep_valid);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    m_n = mn;
    m_d = md;
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    m_n = SIG_W'($urandom);
    m_d = SIG_W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(el));
    if (chk_q) begin
      check({tag, " q"}, 64'(q), 64'(eq));
      check({tag, " sticky"}, 64'(sticky), 64'(es));
    end
    check({tag, " in_ready busy"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      m_n = SIG_W'($urandom);
      check({tag, " hold q"}, 64'(q), 64'(eq));
      check({tag, " hold sticky"}, 64'(sticky), 64'(es));
      check({tag, " hold valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " release valid"}, 64'(out_valid), 64'd0);
    check({tag, " release in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [QBITS-1:0] eq;
    logic             es;
    int               el;
    logic [SIG_W-1:0] rn, rd;
    int               quiet;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    m_n       = '0;
    m_d       = '0;
    repeat (2) @(negedge clk);
    check("reset q", 64'(q), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset sticky", 64'(sticky), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    model(24'h800000, 24'h800000, eq, es, el);
    check("model 1/1", 64'(eq), 64'h2000000);
    do_op("1.0/1.0", 24'h800000, 24'h800000, 26'h2000000, 1'b0, el,
          1'b1, 0, 1'b0);

    model(24'hC00000, 24'h800000, eq, es, el);
    do_op("1.5/1.0", 24'hC00000, 24'h800000, 26'h3000000, 1'b0, el,
          1'b1, 0, 1'b0);

    do_op("1.0/1.5 hold", 24'h800000, 24'hC00000, 26'h1555555, 1'b1,
          QBITS, 1'b1, 5, 1'b1);

    for (int k = 0; k < 8; k++) begin
      rn = {1'b1, 23'($urandom)};
      rd = {1'b1, 23'($urandom)};
      model(rn, rd, eq, es, el);
      do_op($sformatf("rand%0d", k), rn, rd, eq, es, el, 1'b1, 0, 1'b0);
    end

`ifdef FPDIV_MANT_EARLY_TERM_EN
    do_op("div0", 24'h800000, 24'h000000, 26'h3000000, 1'b0, 2,
          1'b1, 0, 1'b0);
`else
    do_op("div0", 24'h800000, 24'h000000, 26'h3FFFFFF, 1'b0, QBITS,
          1'b1, 0, 1'b0);
`endif

    // Abandon an in-flight 1.0/1.5 with reset partway through ITER.
    @(negedge clk);
    in_valid = 1'b1;
    m_n = 24'h800000;
    m_d = 24'hC00000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midreset q", 64'(q), 64'd0);
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd1);
    check("midreset sticky", 64'(sticky), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model(24'hC00000, 24'h800000, eq, es, el);
    do_op("post-reset 1.5/1.0", 24'hC00000, 24'h800000, 26'h3000000,
          1'b0, el, 1'b1, 0, 1'b0);

    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    check("idle no stray valid", 64'(quiet), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
